// File: rtl/lfsr_pkg.sv
// Shared constants and the maximal-length Galois mask table for lfsr_prng.
// Mask bit k-1 set means tap k in the usual tap-list notation.
package lfsr_pkg;

    localparam int unsigned WIDTH_MIN = 4;
    localparam int unsigned WIDTH_MAX = 32;
    localparam int unsigned STEP_MIN  = 1;

    localparam logic [31:0] DEFAULT_SEED = 32'hFFFF_FFFF;

    function automatic logic [31:0] lfsr_mask(input int unsigned width);
        logic [31:0] m;
        case (width)
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            17:      m = 32'h0001_2000;
            18:      m = 32'h0002_0400;
            19:      m = 32'h0004_0023;
            20:      m = 32'h0009_0000;
            21:      m = 32'h0014_0000;
            22:      m = 32'h0030_0000;
            23:      m = 32'h0042_0000;
            24:      m = 32'h00E1_0000;
            25:      m = 32'h0120_0000;
            26:      m = 32'h0200_0023;
            27:      m = 32'h0400_0013;
            28:      m = 32'h0900_0000;
            29:      m = 32'h1400_0000;
            30:      m = 32'h2000_0029;
            31:      m = 32'h4800_0000;
            32:      m = 32'h8020_0003;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational Galois (right-shift) LFSR step.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int unsigned       WIDTH = 12,
    parameter logic [WIDTH-1:0]  MASK  = WIDTH'(lfsr_mask(WIDTH))
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    assign nxt = (cur >> 1) ^ (cur[0] ? MASK : '0);

endmodule

// File: rtl/lfsr_prng.sv
// Parametrised Galois LFSR generator with multi-step advance, seed load,
// all-zero lock-up guard and period measurement.
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int unsigned       WIDTH      = 12,
    parameter logic [WIDTH-1:0]  MASK       = '0,
    parameter logic [WIDTH-1:0]  RESET_SEED = DEFAULT_SEED[WIDTH-1:0],
    parameter int unsigned       STEP       = 1
) (
    input  logic             i_clk,
    input  logic             i_nreset,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    output logic [WIDTH-1:0] o_lfsr,
    output logic             o_bit,
    output logic             o_wrap,
    output logic             o_lockup,
    output logic [WIDTH-1:0] o_period,
    output logic             o_period_vld
);

    localparam logic [WIDTH-1:0] EFF_MASK = (MASK != '0) ? MASK : WIDTH'(lfsr_mask(WIDTH));

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("lfsr_prng: WIDTH out of supported range");
    end
    if (STEP < STEP_MIN || STEP > WIDTH) begin : g_bad_step
        $error("lfsr_prng: STEP must lie in 1..WIDTH");
    end
    if (!EFF_MASK[WIDTH-1]) begin : g_bad_mask
        $error("lfsr_prng: feedback mask must have its top bit set");
    end
    if (RESET_SEED == '0) begin : g_bad_seed
        $error("lfsr_prng: RESET_SEED must be non-zero");
    end

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] period_q;
    logic             period_vld_q;
    logic             wrap_q;
    logic             lockup_q;

    // chain[k] is the state after k single steps; chain[STEP] is what one enabled cycle lands on.
    logic [WIDTH-1:0] chain [0:STEP];
    logic [WIDTH-1:0] stepped;

    assign chain[0] = lfsr_q;

    for (genvar g = 0; g < STEP; g++) begin : g_step
        lfsr_step #(
            .WIDTH (WIDTH),
            .MASK  (EFF_MASK)
        ) u_step (
            .cur (chain[g]),
            .nxt (chain[g+1])
        );
    end

    assign stepped = chain[STEP];

    // NOTE: every register below uses <= so all updates see the pre-edge state of their peers.
    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            lfsr_q       <= RESET_SEED;
            start_q      <= RESET_SEED;
            cnt_q        <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            wrap_q       <= 1'b0;
            lockup_q     <= 1'b0;
        end else begin
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
            if (i_load) begin
                if (i_seed == '0) begin
                    lfsr_q   <= RESET_SEED;
                    start_q  <= RESET_SEED;
                    lockup_q <= 1'b1;
                end else begin
                    lfsr_q  <= i_seed;
                    start_q <= i_seed;
                end
                cnt_q <= '0;
            end else if (i_en) begin
                if (lfsr_q == '0) begin
                    // Zero is a fixed point of the LFSR; recover rather than stick.
                    lfsr_q   <= RESET_SEED;
                    start_q  <= RESET_SEED;
                    cnt_q    <= '0;
                    lockup_q <= 1'b1;
                end else begin
                    lfsr_q <= stepped;
                    if (stepped == start_q) begin
                        wrap_q       <= 1'b1;
                        period_q     <= cnt_q + 1'b1;
                        period_vld_q <= 1'b1;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    assign o_lfsr       = lfsr_q;
    assign o_bit        = lfsr_q[0];
    assign o_wrap       = wrap_q;
    assign o_lockup     = lockup_q;
    assign o_period     = period_q;
    assign o_period_vld = period_vld_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Scoreboard bench for lfsr_prng: four builds (12/1, 12/STEP4, 4/1, 32/1) share
// one stimulus stream; a monitor compares every build's outputs each cycle.
module tb_lfsr_prng;

    localparam int NDUT = 4;
    localparam logic [31:0] W_MASK [NDUT] = '{32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_000F, 32'hFFFF_FFFF};
    localparam logic [31:0] TAPS   [NDUT] = '{32'h0000_0829, 32'h0000_0829, 32'h0000_000C, 32'h8020_0003};
    localparam int          STEPS  [NDUT] = '{1, 4, 1, 1};
    localparam string       NAMES  [NDUT] = '{"w12s1", "w12s4", "w4s1", "w32s1"};

    logic        clk = 1'b0;
    logic        nreset;
    logic        en;
    logic        load;
    logic [31:0] seed;

    always #5 clk = ~clk;

    logic [11:0] a_lfsr, a_period, b_lfsr, b_period;
    logic [3:0]  c_lfsr, c_period;
    logic [31:0] d_lfsr, d_period;
    logic        a_bit, a_wrap, a_lockup, a_vld;
    logic        b_bit, b_wrap, b_lockup, b_vld;
    logic        c_bit, c_wrap, c_lockup, c_vld;
    logic        d_bit, d_wrap, d_lockup, d_vld;

    lfsr_prng #(.WIDTH(12), .STEP(1)) u_dut (
        .i_clk(clk), .i_nreset(nreset), .i_en(en), .i_load(load), .i_seed(seed[11:0]),
        .o_lfsr(a_lfsr), .o_bit(a_bit), .o_wrap(a_wrap), .o_lockup(a_lockup),
        .o_period(a_period), .o_period_vld(a_vld));

    lfsr_prng #(.WIDTH(12), .STEP(4)) u_step4 (
        .i_clk(clk), .i_nreset(nreset), .i_en(en), .i_load(load), .i_seed(seed[11:0]),
        .o_lfsr(b_lfsr), .o_bit(b_bit), .o_wrap(b_wrap), .o_lockup(b_lockup),
        .o_period(b_period), .o_period_vld(b_vld));

    lfsr_prng #(.WIDTH(4), .STEP(1)) u_w4 (
        .i_clk(clk), .i_nreset(nreset), .i_en(en), .i_load(load), .i_seed(seed[3:0]),
        .o_lfsr(c_lfsr), .o_bit(c_bit), .o_wrap(c_wrap), .o_lockup(c_lockup),
        .o_period(c_period), .o_period_vld(c_vld));

    lfsr_prng #(.WIDTH(32), .STEP(1)) u_w32 (
        .i_clk(clk), .i_nreset(nreset), .i_en(en), .i_load(load), .i_seed(seed),
        .o_lfsr(d_lfsr), .o_bit(d_bit), .o_wrap(d_wrap), .o_lockup(d_lockup),
        .o_period(d_period), .o_period_vld(d_vld));

    logic [31:0] act_lfsr   [NDUT];
    logic [31:0] act_period [NDUT];
    logic        act_bit    [NDUT];
    logic        act_wrap   [NDUT];
    logic        act_lockup [NDUT];
    logic        act_vld    [NDUT];

    assign act_lfsr[0] = {20'b0, a_lfsr};   assign act_period[0] = {20'b0, a_period};
    assign act_lfsr[1] = {20'b0, b_lfsr};   assign act_period[1] = {20'b0, b_period};
    assign act_lfsr[2] = {28'b0, c_lfsr};   assign act_period[2] = {28'b0, c_period};
    assign act_lfsr[3] = d_lfsr;            assign act_period[3] = d_period;
    assign act_bit[0] = a_bit;  assign act_wrap[0] = a_wrap;  assign act_lockup[0] = a_lockup;  assign act_vld[0] = a_vld;
    assign act_bit[1] = b_bit;  assign act_wrap[1] = b_wrap;  assign act_lockup[1] = b_lockup;  assign act_vld[1] = b_vld;
    assign act_bit[2] = c_bit;  assign act_wrap[2] = c_wrap;  assign act_lockup[2] = c_lockup;  assign act_vld[2] = c_vld;
    assign act_bit[3] = d_bit;  assign act_wrap[3] = d_wrap;  assign act_lockup[3] = d_lockup;  assign act_vld[3] = d_vld;

    typedef struct {
        int          id;
        logic [31:0] lfsr;
        logic        bitv;
        logic        wrap;
        logic        lockup;
        logic [31:0] period;
        logic        vld;
    } exp_t;

    exp_t sb [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model state, one slot per build.
    logic [31:0] m_s      [NDUT];
    logic [31:0] m_start  [NDUT];
    logic [31:0] m_cnt    [NDUT];
    logic [31:0] m_period [NDUT];
    logic        m_vld    [NDUT];
    logic        m_wrap   [NDUT];
    logic        m_lock   [NDUT];

    function automatic logic [31:0] model_step(input int id, input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int k = 0; k < STEPS[id]; k++)
            r = (r >> 1) ^ (r[0] ? TAPS[id] : 32'h0);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            m_s[i] = W_MASK[i];  m_start[i] = W_MASK[i];
            m_cnt[i] = '0;       m_period[i] = '0;
            m_vld[i] = 1'b0;     m_wrap[i] = 1'b0;  m_lock[i] = 1'b0;
        end
    endtask

    task automatic model_cycle(input logic en_v, input logic load_v, input logic [31:0] seed_v);
        logic [31:0] sd, n;
        for (int i = 0; i < NDUT; i++) begin
            m_wrap[i] = 1'b0;
            m_lock[i] = 1'b0;
            if (load_v) begin
                sd = seed_v & W_MASK[i];
                if (sd == 0) begin
                    m_s[i] = W_MASK[i];  m_start[i] = W_MASK[i];  m_lock[i] = 1'b1;
                end else begin
                    m_s[i] = sd;  m_start[i] = sd;
                end
                m_cnt[i] = '0;
            end else if (en_v) begin
                n = model_step(i, m_s[i]);
                m_s[i] = n;
                if (n == m_start[i]) begin
                    m_wrap[i] = 1'b1;
                    m_period[i] = (m_cnt[i] + 1) & W_MASK[i];
                    m_vld[i] = 1'b1;
                    m_cnt[i] = '0;
                end else begin
                    m_cnt[i] = (m_cnt[i] + 1) & W_MASK[i];
                end
            end
        end
    endtask

    task automatic push_all();
        exp_t e;
        for (int i = 0; i < NDUT; i++) begin
            e.id = i;  e.lfsr = m_s[i];  e.bitv = m_s[i][0];
            e.wrap = m_wrap[i];  e.lockup = m_lock[i];
            e.period = m_period[i];  e.vld = m_vld[i];
            sb.push_back(e);
        end
    endtask

    // Drive one cycle of stimulus, then record what every build must show after the edge.
    task automatic cycle(input logic en_v, input logic load_v, input logic [31:0] seed_v);
        en = en_v;  load = load_v;  seed = seed_v;
        @(posedge clk);
        model_cycle(en_v, load_v, seed_v);
        push_all();
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check({NAMES[e.id], " lfsr"},   act_lfsr[e.id],          e.lfsr);
                check({NAMES[e.id], " bit"},    32'(act_bit[e.id]),      32'(e.bitv));
                check({NAMES[e.id], " wrap"},   32'(act_wrap[e.id]),     32'(e.wrap));
                check({NAMES[e.id], " lockup"}, 32'(act_lockup[e.id]),   32'(e.lockup));
                check({NAMES[e.id], " period"}, act_period[e.id],        e.period);
                check({NAMES[e.id], " vld"},    32'(act_vld[e.id]),      32'(e.vld));
            end
        end
    end

    initial begin
        int n_wrap;
        int wrap_at;

        nreset = 1'b0;  en = 1'b0;  load = 1'b0;  seed = '0;
        #2;
        model_reset();
        push_all();
        #10;
        nreset = 1'b1;

        // Free run from reset for one full 12-bit period.
        n_wrap = 0;  wrap_at = 0;
        for (int k = 1; k <= 4095; k++) begin
            cycle(1'b1, 1'b0, 32'h0);
            if (k == 1) begin
                check("first step lfsr", 32'(a_lfsr), 32'h0FD6);
                check("first step bit",  32'(a_bit),  32'h0);
            end
            if (k == 2) begin
                check("second step lfsr", 32'(a_lfsr), 32'h07EB);
                check("second step bit",  32'(a_bit),  32'h1);
            end
            if (a_wrap) begin
                n_wrap++;
                wrap_at = k;
            end
        end
        check("run1 wrap count",   32'(n_wrap),   32'd1);
        check("run1 wrap cycle",   32'(wrap_at),  32'd4095);
        check("run1 period",       32'(a_period), 32'd4095);
        check("run1 step4 period", 32'(b_period), 32'd4095);
        check("run1 w4 period",    32'(c_period), 32'd15);

        // Load beats enable; then a full period from the new seed.
        cycle(1'b1, 1'b1, 32'h123);
        check("load lfsr",       32'(a_lfsr), 32'h123);
        check("load step4 lfsr", 32'(b_lfsr), 32'h123);
        n_wrap = 0;  wrap_at = 0;
        for (int k = 1; k <= 4095; k++) begin
            cycle(1'b1, 1'b0, 32'h0);
            if (a_wrap) begin
                n_wrap++;
                wrap_at = k;
            end
        end
        check("run2 wrap count", 32'(n_wrap),  32'd1);
        check("run2 wrap cycle", 32'(wrap_at), 32'd4095);
        check("run2 wrap state", 32'(a_lfsr),  32'h123);

        // Zero seed is rejected.
        cycle(1'b0, 1'b1, 32'h0);
        check("zero seed lfsr",   32'(a_lfsr),   32'hFFF);
        check("zero seed lockup", 32'(a_lockup), 32'h1);
        check("zero seed period", 32'(a_period), 32'd4095);
        cycle(1'b0, 1'b0, 32'h0);
        check("lockup drops", 32'(a_lockup), 32'h0);

        // STEP=4 from 0xFFF: FFF -> FD6 -> 7EB -> BDC -> 5EE.
        cycle(1'b1, 1'b0, 32'h0);
        check("step4 lfsr", 32'(b_lfsr), 32'h5EE);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'h0);
        check("step4 hold", 32'(b_lfsr), 32'h5EE);

        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 32'h0);

        // Asynchronous reset between edges.
        @(negedge clk);
        #2;
        nreset = 1'b0;
        #1;
        check("async rst lfsr",     32'(a_lfsr), 32'hFFF);
        check("async rst vld",      32'(a_vld),  32'h0);
        check("async rst w32 lfsr", d_lfsr,      32'hFFFF_FFFF);
        model_reset();
        push_all();
        @(posedge clk);
        #1;
        nreset = 1'b1;

        cycle(1'b1, 1'b0, 32'h0);
        check("w32 first step", d_lfsr,      32'hFFDF_FFFC);
        check("w4 first step",  32'(c_lfsr), 32'hB);
        for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, 32'h0);
        check("w4 period after reset", 32'(c_period), 32'd15);

        en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_prng.md
Name: lfsr_prng

Overview:
- Parametrised Galois LFSR pseudo-random generator. It is the successor to the fixed 12-bit, free-running LFSR used by the VGA random-pattern path.
- Adds the following over the fixed block:
  - selectable width
  - per-cycle step count
  - clock enable
  - runtime seed load
  - all-zero lock-up protection
  - period measurement for self-check
- Sits between the pixel/timing logic and any consumer of random words (colour generation, dither).

Parameters:
- WIDTH, 12: register width; supported range 4..32.
- MASK, 0: Galois feedback mask. 0 means use the maximal-length table entry for WIDTH from lfsr_pkg.
- RESET_SEED, all ones: state loaded at reset and substituted for an all-zero seed.
- STEP, 1: LFSR single-steps applied per enabled cycle; range 1..WIDTH.

Ports:
- i_clk  in  1  clock
- i_nreset  in  1  asynchronous active-low reset
- i_en  in  1  advance enable
- i_load  in  1  seed load strobe
- i_seed  in  WIDTH  seed value, sampled when i_load=1
- o_lfsr  out  WIDTH  current state
- o_bit  out  1  o_lfsr[0]
- o_wrap  out  1  one-cycle pulse: state returned to start state
- o_lockup  out  1  one-cycle pulse: zero seed rejected
- o_period  out  WIDTH  enabled-cycle count of the last completed period
- o_period_vld  out  1  high once o_period holds a measurement

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - o_lfsr=RESET_SEED and start state=RESET_SEED
  - o_wrap=0, o_lockup=0
  - o_period=0, o_period_vld=0
  - cycle counter cnt=0
- Single step (Galois, right shift): s' = (s>>1) ^ (s[0] ? MASK : 0).
  - MASK bit WIDTH-1 must be set.
  - WIDTH=12 table mask is 12'h829 (taps 12,6,4,1), bit-identical to the existing 12-bit generator.
- Enabled cycle (i_en=1, i_load=0):
  - o_lfsr takes the result of STEP chained single steps, all in one cycle.
  - Latency from i_en to the new o_lfsr is 1 cycle.
- i_en=0 and i_load=0: state, cnt and all outputs hold; pulses drop to 0.
- Load (i_load=1) has priority over i_en in the same cycle, and the en step is discarded:
  - i_seed != 0: o_lfsr=i_seed and start state=i_seed.
  - i_seed == 0: o_lfsr=RESET_SEED, start state=RESET_SEED, and o_lockup=1 for one cycle.
  - cnt=0 in both cases; o_period and o_period_vld are unchanged.
- Period tracking, evaluated on each enabled cycle with next state n:
  - cnt increments, wrapping modulo 2^WIDTH.
  - If n == start state: o_wrap=1 next cycle, o_period=cnt+1, o_period_vld=1, cnt=0.
- Width rules:
  - cnt and o_period are WIDTH bits. The maximal period 2^WIDTH-1 fits.
  - With STEP>1, o_wrap fires only when an enabled cycle lands exactly on the start state.
- Runtime lock-up guard: if the state is ever 0 (not reachable by legal operation), the next enabled cycle forces RESET_SEED and pulses o_lockup.
- Reset mid-operation: immediate return to reset values regardless of i_en/i_load.
- Outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- lfsr_pkg holds:
  - function lfsr_mask(width) returning the maximal-length mask table for 4..32
  - default seed constant
  - parameter range-check constants
- Sub-module lfsr_step: combinational single step, parameterised by WIDTH and MASK. It is instantiated STEP times in a generate chain.
- Sequencing, load, period and lock-up logic stay in lfsr_prng.

Test Plan:
- Reset with WIDTH=12, STEP=1, then i_en=1 for 2 cycles -> o_lfsr 0xFFF, then 0xFD6, then 0x7EB; o_bit 1,0,1.
- WIDTH=12, i_en held 4095 cycles from reset -> o_wrap pulses exactly on cycle 4095; o_period=4095, o_period_vld=1; no earlier repeat of 0xFFF.
- i_load=1 with i_seed=0x123 and i_en=1 in the same cycle -> o_lfsr=0x123 next cycle (no step applied), cnt cleared; after 4095 enables o_wrap pulses at 0x123.
- i_load=1 with i_seed=0 -> o_lfsr=0xFFF, o_lockup high exactly one cycle, o_period unchanged.
- STEP=4, WIDTH=12, one enabled cycle from 0xFFF -> o_lfsr equals 4 single steps from 0xFFF (bench model); i_en=0 holds the state.
- Assert i_nreset low asynchronously mid-run (between clock edges) -> o_lfsr=0xFFF immediately, o_period_vld=0; WIDTH=4 and WIDTH=32 builds run a period/spot-check against the table.
